// File: rtl/traffic_phase_controller_pkg.sv
// Shared types for the traffic phase controller.
//   CounterSignal : 32-bit cycle/packet counter type
//   TPCConfig     : run lengths (warm-up, measurement, drain timeout)
//   TPCState      : controller state encoding
//   sat_inc       : increment that holds at all-ones
package traffic_phase_controller_pkg;

    localparam int unsigned COUNTER_W = 32;

    typedef logic [COUNTER_W-1:0] CounterSignal;

    typedef struct packed {
        CounterSignal warmup_cycles;
        CounterSignal measure_cycles;
        CounterSignal drain_timeout;
    } TPCConfig;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } TPCState;

    function automatic CounterSignal sat_inc(input CounterSignal v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_counter.sv
// Saturating up/down counter used for the outstanding-packet count.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : one-step up / down request; both or neither leaves value unchanged
//   clear      : forces value to zero, takes priority over inc/dec
//   value      : registered count
//   overflow   : this cycle's increment was blocked at all-ones (combinational)
//   underflow  : this cycle's decrement was blocked at zero (combinational)
module saturating_updown_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d   = value_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (inc && !dec) begin
            if (value_q == '1) overflow = 1'b1;
            else               value_d  = value_q + ONE;
        end else if (dec && !inc) begin
            if (value_q == '0) underflow = 1'b1;
            else               value_d   = value_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: sequences a PIFO run through warm-up,
// measurement and drain, tracking packets still held in the PIFO.
// Optional feature macro: TPC_DRAIN_TIMEOUT_EN (drain ends after
// drain_timeout cycles even with packets outstanding).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i__config         : run lengths, stable between start and done
//   i__start          : pulse, begins a run from IDLE or DONE
//   i__enqueue        : packet accepted by the PIFO this cycle
//   i__dequeue        : packet left the PIFO this cycle
//   o__inject_phase   : generators may inject (WARMUP, MEASURE)
//   o__receive_phase  : receiver may dequeue (WARMUP, MEASURE, DRAIN)
//   o__measure_phase  : statistics window open (MEASURE)
//   o__phase_count    : cycles elapsed in the current phase
//   o__outstanding    : packets currently in the PIFO
//   o__done           : run complete
//   o__timeout        : drain ended by timeout (sticky until next start)
//   o__error          : outstanding counter saturated (sticky until next start)
//
// state   | meaning
// IDLE    | after reset, waiting for start
// WARMUP  | injecting, statistics closed
// MEASURE | injecting, statistics window open
// DRAIN   | no injection, waiting for the PIFO to empty
// DONE    | run complete, phase_count frozen
module traffic_phase_controller
    import traffic_phase_controller_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  TPCConfig     i__config,
    input  logic         i__start,
    input  logic         i__enqueue,
    input  logic         i__dequeue,
    output logic         o__inject_phase,
    output logic         o__receive_phase,
    output logic         o__measure_phase,
    output CounterSignal o__phase_count,
    output CounterSignal o__outstanding,
    output logic         o__done,
    output logic         o__timeout,
    output logic         o__error
);

    TPCState      state_q, state_d;
    CounterSignal phase_count_q, phase_count_d;
    logic         error_q, error_d;
    logic         timeout_q, timeout_d;
    logic         start_run;
    logic         cnt_ovf, cnt_udf;
    CounterSignal outstanding;

    assign start_run = i__start && ((state_q == IDLE) || (state_q == DONE));

    saturating_updown_counter #(
        .WIDTH (COUNTER_W)
    ) u_outstanding (
        .clk       (clk),
        .reset     (reset),
        .inc       (i__enqueue),
        .dec       (i__dequeue),
        .clear     (start_run),
        .value     (outstanding),
        .overflow  (cnt_ovf),
        .underflow (cnt_udf)
    );

    always_comb begin
        state_d       = state_q;
        phase_count_d = phase_count_q;
        timeout_d     = timeout_q;
        error_d       = error_q | cnt_ovf | cnt_udf;
        case (state_q)
            IDLE, DONE: begin
                if (i__start) begin
                    phase_count_d = '0;
                    timeout_d     = 1'b0;
                    error_d       = 1'b0;
                    if (i__config.warmup_cycles != '0)       state_d = WARMUP;
                    else if (i__config.measure_cycles != '0) state_d = MEASURE;
                    else                                     state_d = DRAIN;
                end
            end
            WARMUP: begin
                if (phase_count_q == i__config.warmup_cycles - 32'd1) begin
                    phase_count_d = '0;
                    state_d = (i__config.measure_cycles != '0) ? MEASURE : DRAIN;
                end else begin
                    phase_count_d = sat_inc(phase_count_q);
                end
            end
            MEASURE: begin
                if (phase_count_q == i__config.measure_cycles - 32'd1) begin
                    phase_count_d = '0;
                    state_d       = DRAIN;
                end else begin
                    phase_count_d = sat_inc(phase_count_q);
                end
            end
            DRAIN: begin
                // The exit cycle still counts, so DONE shows the drain length.
                phase_count_d = sat_inc(phase_count_q);
                if (outstanding == '0) begin
                    state_d = DONE;
                end
`ifdef TPC_DRAIN_TIMEOUT_EN
                else if ((i__config.drain_timeout != '0) &&
                         (phase_count_q == i__config.drain_timeout - 32'd1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_count_q <= '0;
            error_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_count_q <= phase_count_d;
            error_q       <= error_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o__inject_phase  = (state_q == WARMUP) || (state_q == MEASURE);
    assign o__receive_phase = (state_q == WARMUP) || (state_q == MEASURE) || (state_q == DRAIN);
    assign o__measure_phase = (state_q == MEASURE);
    assign o__done          = (state_q == DONE);
    assign o__phase_count   = phase_count_q;
    assign o__outstanding   = outstanding;
    assign o__error         = error_q;

`ifdef TPC_DRAIN_TIMEOUT_EN
    assign o__timeout = timeout_q;
`else
    logic unused_drain_timeout;
    logic unused_timeout_q;
    assign unused_drain_timeout = ^i__config.drain_timeout;
    assign unused_timeout_q     = timeout_q;
    assign o__timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;
    import traffic_phase_controller_pkg::*;

    logic         clk = 1'b0;
    logic         reset, start, enq, deq;
    TPCConfig     cfg;
    logic         inj, rcv, meas, done, tmo, err;
    CounterSignal pc, outst;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk              (clk),
        .reset            (reset),
        .i__config        (cfg),
        .i__start         (start),
        .i__enqueue       (enq),
        .i__dequeue       (deq),
        .o__inject_phase  (inj),
        .o__receive_phase (rcv),
        .o__measure_phase (meas),
        .o__phase_count   (pc),
        .o__outstanding   (outst),
        .o__done          (done),
        .o__timeout       (tmo),
        .o__error         (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          inj, rcv, meas, done, to, err;
        int unsigned pc, outst;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a run is described by k, the 1-based cycle index since
    // start; phase membership follows from W and M by plain arithmetic.
    bit          m_active = 0, m_done = 0, m_to = 0, m_err = 0;
    int unsigned m_k = 0, m_out = 0, m_dpc = 0, m_w = 0, m_m = 0, m_dt = 0;

    function automatic bit to_enabled();
`ifdef TPC_DRAIN_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_in_inject();
        return m_active && (m_k <= m_w + m_m);
    endfunction

    function automatic bit m_in_measure();
        return m_active && (m_k > m_w) && (m_k <= m_w + m_m);
    endfunction

    function automatic int unsigned m_drain_idx();
        return (m_active && m_k > m_w + m_m) ? m_k - m_w - m_m : 0;
    endfunction

    function automatic void model_step(input bit st, input bit en, input bit de, input bit rs);
        int unsigned d;
        if (rs) begin
            m_active = 0; m_done = 0; m_k = 0; m_out = 0; m_err = 0; m_to = 0; m_dpc = 0;
        end else if (st && !m_active) begin
            m_active = 1; m_done = 0; m_k = 1; m_out = 0; m_err = 0; m_to = 0;
            m_w = cfg.warmup_cycles; m_m = cfg.measure_cycles; m_dt = cfg.drain_timeout;
        end else begin
            if (m_active) begin
                d = m_drain_idx();
                if (d != 0 && m_out == 0) begin
                    m_active = 0; m_done = 1; m_dpc = d;
                end else if (d != 0 && to_enabled() && m_dt != 0 && d == m_dt) begin
                    m_active = 0; m_done = 1; m_dpc = d; m_to = 1;
                end else begin
                    m_k++;
                end
            end
            if (en && !de) m_out++;
            else if (de && !en) begin
                if (m_out == 0) m_err = 1;
                else            m_out--;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e = '{default: 0};
        if (m_active) begin
            e.rcv  = 1;
            e.inj  = m_in_inject();
            e.meas = m_in_measure();
            if (m_k <= m_w)             e.pc = m_k - 1;
            else if (m_k <= m_w + m_m)  e.pc = m_k - m_w - 1;
            else                        e.pc = m_k - m_w - m_m - 1;
        end else if (m_done) begin
            e.done = 1;
            e.pc   = m_dpc;
        end
        e.outst = m_out;
        e.err   = m_err;
        e.to    = m_to;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    // Monitor: compare the DUT state after each edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inject",      {31'd0, inj},  {31'd0, e.inj});
                chk("receive",     {31'd0, rcv},  {31'd0, e.rcv});
                chk("measure",     {31'd0, meas}, {31'd0, e.meas});
                chk("done",        {31'd0, done}, {31'd0, e.done});
                chk("timeout",     {31'd0, tmo},  {31'd0, e.to});
                chk("error",       {31'd0, err},  {31'd0, e.err});
                chk("outstanding", outst,         e.outst);
                chk("phase_count", pc,            e.pc);
            end
        end
    end

    task automatic cyc(input bit st, input bit en, input bit de, input bit rs = 1'b0);
        @(negedge clk);
        start = st; enq = en; deq = de; reset = rs;
        model_step(st, en, de, rs);
        push_exp();
    endtask

    task automatic set_cfg(input int unsigned w, input int unsigned m, input int unsigned t);
        cfg.warmup_cycles  = w;
        cfg.measure_cycles = m;
        cfg.drain_timeout  = t;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        int sent;
        int unsigned d;
        bit e_r, d_r;
        reset = 1'b1; start = 1'b0; enq = 1'b0; deq = 1'b0;
        cfg = '0;

        // Reset state
        repeat (3) cyc(0, 0, 0, 1);

        // Nominal run: warmup 3, measure 5, no traffic
        set_cfg(3, 5, 0);
        run_idle(5);
        cyc(1, 0, 0);
        run_idle(14);

        // Zero lengths: straight into DRAIN then DONE
        set_cfg(0, 0, 0);
        cyc(1, 0, 0);
        run_idle(4);

        // Drain wait: 4 enqueues in MEASURE, dequeues at drain cycles 2,5,6,9
        set_cfg(2, 6, 0);
        cyc(1, 0, 0);
        sent = 0;
        for (int i = 0; i < 30; i++) begin
            d = m_drain_idx();
            if (m_in_measure() && sent < 4) begin
                cyc(0, 1, 0); sent++;
            end else if (d == 2 || d == 5 || d == 6 || d == 9) begin
                cyc(0, 0, 1);
            end else begin
                cyc(0, 0, 0);
            end
        end

        // Simultaneous events and underflow while in DONE
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        run_idle(2);
        set_cfg(1, 1, 0);
        cyc(1, 0, 0);
        run_idle(6);

        // Drain timeout: one packet never dequeued
        set_cfg(1, 2, 8);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        run_idle(20);
        cyc(0, 0, 0, 1);
        run_idle(2);

        // Reset mid-MEASURE, then restart with a full warm-up
        set_cfg(3, 6, 0);
        cyc(1, 0, 0);
        run_idle(5);
        cyc(0, 0, 0, 1);
        run_idle(2);
        cyc(1, 0, 0);
        run_idle(15);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 12));
            cyc(1, 0, 0);
            for (int i = 0; i < 120 && m_active; i++) begin
                e_r = m_in_inject() && ($urandom_range(0, 99) < 50);
                d_r = ($urandom_range(0, 99) < 35);
                cyc(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, e_r, d_r);
            end
            if (m_active || $urandom_range(0, 3) == 0) cyc(0, 0, 0, 1);
            run_idle($urandom_range(1, 3));
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Testbench-side sequencer that drives a PIFO run through four timed phases: warm-up, measurement, drain and done. It produces the phase enables and the per-phase cycle count consumed by the traffic generators and `traffic_receiver`. It also tracks packets still outstanding in the PIFO, so the drain phase ends exactly when the queue is empty. It sits at the top of the common testbench, alongside the generator and receiver instances.

## Interface
Parameters: none. All widths come from the shared testbench header.

Ports:
- `clk`  in  1  testbench clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `i__config`  in  `TPCConfig`  run lengths; must be held stable between `i__start` and `o__done`
  - `warmup_cycles` (`CounterSignal`)
  - `measure_cycles` (`CounterSignal`)
  - `drain_timeout` (`CounterSignal`)
- `i__start`  in  1  single-cycle pulse that begins a run
- `i__enqueue`  in  1  a packet was accepted by the PIFO this cycle
- `i__dequeue`  in  1  a packet left the PIFO this cycle (the receiver's `o__dequeue`)
- `o__inject_phase`  out  1  generators may inject
- `o__receive_phase`  out  1  receiver may dequeue
- `o__measure_phase`  out  1  statistics window is open
- `o__phase_count`  out  `CounterSignal`  cycles elapsed in the current phase
- `o__outstanding`  out  `CounterSignal`  packets currently held in the PIFO
- `o__done`  out  1  run complete; held high
- `o__timeout`  out  1  drain ended by timeout; sticky until the next start
- `o__error`  out  1  outstanding counter underflowed or overflowed; sticky until the next start

## Operation
- **State machine:** IDLE, WARMUP, MEASURE, DRAIN, DONE. State is held in a register.
- **Phase outputs are decoded from the registered state:**
  - WARMUP: inject=1, receive=1
  - MEASURE: inject=1, receive=1, measure=1
  - DRAIN: receive=1 only
  - IDLE and DONE: all three are 0
- **IDLE or DONE with `i__start`=1:**
  - Clear `phase_count`, `outstanding`, `timeout`, `error` and `done`.
  - Go to WARMUP if `warmup_cycles`≠0.
  - Otherwise go to MEASURE if `measure_cycles`≠0.
  - Otherwise go to DRAIN.
- **`i__start` in WARMUP, MEASURE or DRAIN** is ignored.
- **WARMUP:** `phase_count` increments every cycle.
  - At `phase_count`==`warmup_cycles`−1, go to MEASURE (or to DRAIN if `measure_cycles`==0) and clear `phase_count`.
  - WARMUP therefore lasts exactly `warmup_cycles` cycles.
- **MEASURE:** lasts exactly `measure_cycles` cycles by the same rule, then goes to DRAIN with `phase_count` cleared.
- **DRAIN:** `phase_count` increments every cycle.
  - Go to DONE on the first cycle in which the registered `o__outstanding`==0.
  - An entry with zero outstanding therefore spends exactly one cycle in DRAIN.
- **DONE:** `o__done`=1 and `phase_count` is frozen. The controller stays in DONE until the next start or reset.
- **Outstanding counter** is updated in every state:
  - +1 on `i__enqueue` only
  - −1 on `i__dequeue` only
  - unchanged when both or neither are asserted
- **Counter saturation:**
  - A decrement at 0 stays at 0 and sets `o__error`.
  - An increment at all-ones stays at all-ones and sets `o__error`.
- **`phase_count`** saturates at all-ones and never wraps.

## Timing
- **Reset values:** state=IDLE; every output is 0, including `phase_count` and `outstanding`.
- **All outputs are registered.** No combinational path runs from any input to any output.
- **Start latency:** `i__start` sampled high at edge *t* → phase outputs reflect the new state after edge *t*, i.e. during cycle *t*+1. `phase_count` reads 0 in that first cycle.
- **Outstanding latency:** `o__outstanding` reflects enqueue/dequeue pulses one cycle after they are sampled.
  - A dequeue and the DRAIN exit cannot coincide in one cycle; DONE follows the cycle after the last dequeue is counted.
- **Reset mid-run:** returns to IDLE on the next edge with all outputs cleared. Any in-flight count is discarded.

## Configuration
- **`TPC_DRAIN_TIMEOUT_EN` defined:**
  - In DRAIN, if `phase_count`==`drain_timeout`−1 and outstanding≠0, go to DONE and set `o__timeout`.
  - `drain_timeout`==0 disables the timeout.
- **`TPC_DRAIN_TIMEOUT_EN` undefined:**
  - DRAIN exits only on outstanding==0.
  - `o__timeout` is tied to 0 and the `drain_timeout` field is ignored.

## Structure
- **Shared testbench header** holds:
  - the `TPCConfig` packed struct
  - the `CounterSignal` typedef (32 bits)
  - a `TPCState` enum with encodings IDLE=0, WARMUP=1, MEASURE=2, DRAIN=3, DONE=4
- **One sub-module, `saturating_updown_counter`,** implements the outstanding counter.
  - Ports: inc, dec, clear, value, overflow, underflow.
  - The width is a parameter.

## Test plan
- **Nominal run:** warmup=3, measure=5, no traffic, start at cycle 10 → inject high for cycles 11–18; measure high for cycles 14–18; DRAIN one cycle (19); `o__done` high from cycle 20.
- **Zero lengths:** warmup=0, measure=0 → start goes directly to DRAIN, then DONE; `o__inject_phase` never asserts.
- **Drain wait:** 4 enqueues during MEASURE, with dequeues at DRAIN cycles 2, 5, 6, 9 → `o__outstanding` steps 4→0; DONE occurs the cycle after the 0 is registered.
- **Simultaneous and underflow events:** enqueue and dequeue in the same cycle → `o__outstanding` unchanged. A dequeue at outstanding 0 → value stays 0 and `o__error`=1 until the next start.
- **Timeout (with `TPC_DRAIN_TIMEOUT_EN`):** drain_timeout=8, one packet never dequeued → DONE after 8 DRAIN cycles with `o__timeout`=1. Without the macro, the controller stays in DRAIN indefinitely.
- **Reset mid-MEASURE, then restart:** all outputs are 0 the next cycle; a new `i__start` produces a full WARMUP of exactly `warmup_cycles` cycles.
